// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions.
//   ZERO_REG   : index of the hard-wired zero register
//   RD_MAX_W   : storage width of a register index inside a scoreboard entry
//   sb_entry_t : one in-flight instruction slot {v, rw, ld, rd}
//   action_e   : decode-stage interlock action
package cpu_pkg;

   localparam int unsigned ZERO_REG = 31;

   // Scoreboard entries store indices at this width; narrower REG_W values are zero-extended.
   localparam int unsigned RD_MAX_W = 8;

   typedef struct packed {
      logic                v;   // slot holds a real instruction
      logic                rw;  // instruction writes rd
      logic                ld;  // instruction is a load
      logic [RD_MAX_W-1:0] rd;
   } sb_entry_t;

   typedef enum logic [1:0] {
      ACT_RUN,
      ACT_STALL,
      ACT_FLUSH,
      ACT_HOLD
   } action_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset (count -> 0)
//   clr   : synchronous clear, wins over en
//   en    : count up by one unless already at LIMIT
//   count : current value
module sat_counter #(
   parameter int unsigned W     = 16,
   parameter logic [W-1:0] LIMIT = {W{1'b1}}
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count_q <= '0;
      end else if (en && (count_q != LIMIT)) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage interlock controller.
// Tracks destinations of instructions in EX/MEM/WB, detects RAW hazards for the
// instruction in ID and drives the IF/ID and ID/EX sequencing controls.
//   clk, rst                       : clock, synchronous active-high reset
//   id_*                           : operand/destination info of the ID instruction
//   branch_taken                   : branch resolved taken in EX
//   ext_hold                       : memory busy, freeze everything
//   pc_write, ifid_write           : advance enables
//   ifid_flush, idex_bubble        : NOP insertion controls
//   stall_count, flush_count       : saturating statistics
//   hazard_timeout                 : sticky flag, PC frozen for too long
// REG_W must not exceed cpu_pkg::RD_MAX_W.
module id_hazard_ctrl #(
   parameter int unsigned REG_W      = 5,
   parameter int unsigned ZERO_REG   = cpu_pkg::ZERO_REG,
   parameter int unsigned FORWARDING = 0,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned MAX_STALL  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic             id_uses_rn,
   input  logic             id_uses_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             branch_taken,
   input  logic             ext_hold,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count,
   output logic             hazard_timeout
);

   import cpu_pkg::*;

   localparam int unsigned         FRZ_W    = $clog2(MAX_STALL + 1);
   localparam logic [RD_MAX_W-1:0] ZERO_IDX = RD_MAX_W'(ZERO_REG);

   sb_entry_t  ex_q, mem_q, wb_q;
   sb_entry_t  id_entry;
   action_e    act;
   logic       hazard;
   logic [FRZ_W-1:0] frz_count;
   logic       timeout_q;

   // With forwarding, only a load in EX can't be bypassed; without it, EX and MEM
   // producers both block. WB needs no check: the register file writes before it reads.
   function automatic logic src_match(input sb_entry_t ex, input sb_entry_t mem,
                                      input logic [RD_MAX_W-1:0] r);
      logic ex_hit;
      logic mem_hit;
      ex_hit  = ex.v & ex.rw & (ex.rd == r) & ((FORWARDING == 0) | ex.ld);
      mem_hit = (FORWARDING == 0) & mem.v & mem.rw & (mem.rd == r);
      return (r != ZERO_IDX) & (ex_hit | mem_hit);
   endfunction

   assign id_entry = '{v: id_valid, rw: id_regwrite, ld: id_memread, rd: RD_MAX_W'(id_rd)};

   always_comb begin
      hazard = id_valid &
               ((id_uses_rn & src_match(ex_q, mem_q, RD_MAX_W'(id_rn))) |
                (id_uses_rm & src_match(ex_q, mem_q, RD_MAX_W'(id_rm))));

      if (rst) begin
         act = ACT_RUN;
      end else if (ext_hold) begin
         act = ACT_HOLD;
      end else if (branch_taken) begin
         act = ACT_FLUSH;
      end else if (hazard) begin
         act = ACT_STALL;
      end else begin
         act = ACT_RUN;
      end

      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      unique case (act)
         ACT_STALL: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
         end
         ACT_FLUSH: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
         end
         ACT_HOLD: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
         end
         default: ;
      endcase
   end

   // Scoreboard shift; frozen while memory holds the pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else if (act != ACT_HOLD) begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= (act == ACT_RUN) ? id_entry : '0;
      end
   end

   // WB and MEM.ld are carried for completeness of the pipeline picture only.
   logic unused_sb;
   assign unused_sb = ^{wb_q, mem_q.ld};

   sat_counter #(
      .W     (CNT_W),
      .LIMIT ({CNT_W{1'b1}})
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .en    (act == ACT_STALL),
      .count (stall_count)
   );

   sat_counter #(
      .W     (CNT_W),
      .LIMIT ({CNT_W{1'b1}})
   ) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .en    (act == ACT_FLUSH),
      .count (flush_count)
   );

   sat_counter #(
      .W     (FRZ_W),
      .LIMIT (FRZ_W'(MAX_STALL))
   ) u_frz_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (pc_write),
      .en    (~pc_write),
      .count (frz_count)
   );

   // Another frozen cycle with the counter already at the limit would exceed it.
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_q <= 1'b0;
      end else if (!pc_write && (frz_count == FRZ_W'(MAX_STALL))) begin
         timeout_q <= 1'b1;
      end
   end

   assign hazard_timeout = timeout_q;

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Decode-stage interlock controller for the five-stage pipeline. It tracks destination registers of instructions in flight in EX, MEM and WB, and detects RAW hazards against the instruction in ID. It sequences the IF/ID and ID/EX pipeline registers: stall, bubble, flush or freeze. It sits beside the instruction-decode stage, takes branch resolution from execution and a hold request from memory, and keeps stall/flush statistics.

## Interface
- `REG_W`, default 5: register index width.
- `ZERO_REG`, default 31: hard-wired zero register; never creates a hazard.
- `FORWARDING`, default 0: 0 means no bypass network; 1 means EX/MEM bypass exists, so only load-use stalls.
- `CNT_W`, default 16: statistics counter width.
- `MAX_STALL`, default 16: consecutive frozen-PC cycles tolerated before timeout.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rn` in REG_W: first source register.
- `id_rm` in REG_W: second source register, already selected by Reg2Loc.
- `id_uses_rn`, `id_uses_rm` in 1: the source is actually read.
- `id_rd` in REG_W: destination register.
- `id_regwrite` in 1: the ID instruction writes `id_rd`.
- `id_memread` in 1: the ID instruction is a load.
- `branch_taken` in 1: the branch in EX is taken (PCSrc).
- `ext_hold` in 1: memory busy; freeze the whole pipeline.
- `pc_write` out 1: PC may advance.
- `ifid_write` out 1: IF/ID may load.
- `ifid_flush` out 1: clear IF/ID to a NOP.
- `idex_bubble` out 1: load a NOP into ID/EX.
- `stall_count` out CNT_W: saturating count of hazard-stall cycles.
- `flush_count` out CNT_W: saturating count of taken-branch flushes.
- `hazard_timeout` out 1: sticky error flag.

## Operation
- **Scoreboard.** Three registered entries, EX, MEM and WB, each holding {v, rw, ld, rd}.
- **Match.** `match(r) = r != ZERO_REG` and either of:
  - EX.v & EX.rw & EX.rd == r & (FORWARDING == 0 or EX.ld);
  - FORWARDING == 0 & MEM.v & MEM.rw & MEM.rd == r.
- WB is never compared. The register file writes before it reads within a cycle.
- **Hazard.** `hazard = id_valid & ((id_uses_rn & match(id_rn)) | (id_uses_rm & match(id_rm)))`.
- **Action priority, highest first:**
  - **HOLD** (`ext_hold`): pc_write=0, ifid_write=0, flush=0, bubble=0. The scoreboard is frozen and counters are unchanged.
  - **FLUSH** (`branch_taken`): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. `flush_count` increments. Any concurrent hazard is ignored and not counted.
  - **STALL** (`hazard`): pc_write=0, ifid_write=0, idex_bubble=1. `stall_count` increments.
  - **RUN**: pc_write=1, ifid_write=1, flush=0, bubble=0.
- **Scoreboard update, every non-HOLD cycle:**
  - WB takes MEM; MEM takes EX.
  - EX takes {id_valid, id_regwrite, id_memread, id_rd} in RUN, and all-zero (bubble) in STALL or FLUSH.
- **Counters.** Saturate at all-ones and never wrap.
- **Timeout.** The frozen counter increments each cycle with pc_write=0 and clears on pc_write=1. It saturates at MAX_STALL.
  - `hazard_timeout` sets when the counter would exceed MAX_STALL.
  - The flag stays set until `rst`.

## Timing
- Action outputs are combinational from current inputs and the registered scoreboard, valid in the same cycle. The scoreboard, counters and timeout are registered.
- Reset, registered on the clk edge with `rst`=1:
  - scoreboard all v=0;
  - `stall_count` = 0, `flush_count` = 0, `hazard_timeout` = 0, frozen counter = 0.
  - During reset the action outputs force RUN values (pc_write=1, ifid_write=1, flush=0, bubble=0) regardless of inputs.
- Reset mid-stall: the next cycle starts with an empty scoreboard, so no residual stall.
- Stall length for a dependent instruction immediately following its producer:
  - FORWARDING=0: 2 cycles, whether the producer is ALU or load.
  - FORWARDING=1: 1 cycle for a load producer, 0 for an ALU producer.
  - Producer two ahead, FORWARDING=0: 1 cycle.
- A held `branch_taken` (HOLD concurrent) is acted on in the first non-HOLD cycle, exactly once.

## Structure
- Shared package `cpu_pkg`:
  - ZERO_REG;
  - the scoreboard entry struct {v, rw, ld, rd};
  - the action encoding enum {ACT_RUN, ACT_STALL, ACT_FLUSH, ACT_HOLD}.
- One sub-module, `sat_counter` (CNT_W, enable, sync clear, saturating). It is instantiated three times: stall count, flush count and frozen-cycle count.
- The scoreboard shift and action decode stay in `id_hazard_ctrl`.

## Test plan
- **Reset.** Hold rst 3 cycles with branch_taken=1. Required: pc_write=1, ifid_write=1, flush=0, bubble=0 and all counts 0 throughout and after.
- **ALU RAW, FORWARDING=0.** ADD X1 (rd=1, regwrite), then SUB reading rn=1. Required: 2 stall cycles (pc_write=0, bubble=1), then RUN; stall_count=2.
- **FORWARDING=1.**
  - LDUR X2 then ADD reading rm=2: exactly 1 stall; stall_count=1.
  - ADD X3 then SUB reading X3: 0 stalls.
- **Zero register.** Producer rd=31, consumer rn=31. Required: no stall; stall_count stays 0.
- **Branch over stall.** Hazard and branch_taken in the same cycle. Required: ifid_flush=1, idex_bubble=1, pc_write=1; flush_count=1; stall_count unchanged.
- **Hold and timeout, MAX_STALL=16.** ext_hold for 20 cycles with branch_taken=1 asserted at the first cycle. Required:
  - scoreboard frozen; no flush during hold;
  - hazard_timeout rises on hold cycle 17 and stays set after the hold drops;
  - exactly one flush occurs after the hold; flush_count=1.
